wide_alu_seq: RTL and testbench

- Multi-cycle initiator that drives the 8-bit combinational ALU to execute 16-bit operations.
- Accepts one 16-bit request over a valid/ready handshake.
- Issues the LSW microcode op, then the MSW microcode op, carrying SC_OUT of the LSW step into SC_IN of the MSW step.
- Assembles the 16-bit result and returns it on a valid/ready response channel.
- Sits between the datapath controller and the ALU instance.

---
 rtl/wide_alu_seq_pkg.sv | 23 ++
 rtl/wide_alu_seq_if.sv | 26 ++
 rtl/alu.sv | 35 +++
 rtl/wide_alu_opmap.sv | 18 +
 rtl/wide_alu_seq.sv | 122 ++++++++++++
 tb/tb_wide_alu_seq.sv | 215 +++++++++++++++++++++
 6 files changed

// File: rtl/wide_alu_seq_pkg.sv
// Shared types for the 16-bit sequencer and the 8-bit ALU it drives.
// The optional local carry output is enabled by the WIDE_ALU_CARRY_EN macro (see wide_alu_seq.sv).
package wide_alu_seq_pkg;
  localparam int ALU_DW  = 8;
  localparam int ALU_OPW = 4;

  typedef enum logic [ALU_OPW-1:0] {
    kADDL = 4'h0,
    kADDU = 4'h1,
    kLSAL = 4'h2,
    kLSAU = 4'h3,
    kXOR  = 4'h4
  } op_mne;

  typedef enum logic [1:0] {
    ADD16    = 2'b00,
    LSL16    = 2'b01,
    XOR16    = 2'b10,
    WIDE_ILL = 2'b11
  } wide_op_t;

  typedef enum logic [1:0] {IDLE, LSW, MSW, DONE} wseq_state_t;
endpackage

// File: rtl/wide_alu_seq_if.sv
// Request/response channels of the wide ALU sequencer.
interface wide_alu_seq_if
  import wide_alu_seq_pkg::*;
#(
  parameter int DW = 8
);
  logic            req_valid;
  logic            req_ready;
  wide_op_t        req_op;
  logic [2*DW-1:0] req_a;
  logic [2*DW-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [2*DW-1:0] rsp_data;
  logic            rsp_err;
  logic            rsp_carry;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_carry
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err, rsp_carry
  );
endinterface

// File: rtl/alu.sv
// 8-bit combinational ALU: add with carry, shift-left through carry, xor.
module alu
  import wide_alu_seq_pkg::*;
#(
  parameter int DW = 8
) (
  input  op_mne         op,
  input  logic [DW-1:0] inputa,
  input  logic [DW-1:0] inputb,
  input  logic          sc_in,
  output logic [DW-1:0] out,
  output logic          sc_out
);
  logic [DW:0] sum;
  assign sum = {1'b0, inputa} + {1'b0, inputb} + {{DW{1'b0}}, sc_in};

  always_comb begin
    out    = '0;
    sc_out = 1'b0;
    case (op)
      kADDL: {sc_out, out} = sum;
      kADDU: out = sum[DW-1:0];
      kLSAL, kLSAU: begin
        out    = {inputa[DW-2:0], sc_in};
        sc_out = inputa[DW-1];
      end
      // SC_OUT carries no meaning for xor; it is left as parity.
      kXOR: begin
        out    = inputa ^ inputb;
        sc_out = ^inputa;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/wide_alu_opmap.sv
// Microcode map from (wide op, half) to the ALU opcode.
module wide_alu_opmap
  import wide_alu_seq_pkg::*;
(
  input  wide_op_t op,
  input  logic     msw,
  output op_mne    alu_op
);
  always_comb begin
    alu_op = kADDL;
    case (op)
      ADD16:   alu_op = msw ? kADDU : kADDL;
      LSL16:   alu_op = msw ? kLSAU : kLSAL;
      XOR16:   alu_op = kXOR;
      default: alu_op = kADDL;
    endcase
  end
endmodule

// File: rtl/wide_alu_seq.sv
// Sequences one 16-bit op as two 8-bit ALU steps (LSW then MSW, carry chained).
// Define WIDE_ALU_CARRY_EN to compute RSP_CARRY locally; otherwise it is tied 0.
module wide_alu_seq
  import wide_alu_seq_pkg::*;
#(
  parameter int DW  = 8,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  wide_alu_seq_if.slave  bus,
  output logic [OPW-1:0] alu_op,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic           alu_sc_in,
  input  logic [DW-1:0]  alu_out,
  input  logic           alu_sc_out
);
  wseq_state_t     state, state_nx;
  wide_op_t        op_q;
  logic [2*DW-1:0] a_q, b_q, rsp_data_q;
  logic [DW-1:0]   res_lo_q;
  logic            cy_q, rsp_err_q, accept;
  op_mne           map_op;

  wide_alu_opmap u_opmap (.op(op_q), .msw(state == MSW), .alu_op(map_op));

  assign accept = bus.req_valid && (state == IDLE);

  always_comb begin
    state_nx      = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    alu_op        = OPW'(kADDL);
    alu_a         = '0;
    alu_b         = '0;
    alu_sc_in     = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nx = (bus.req_op == WIDE_ILL) ? DONE : LSW;
      end
      LSW: begin
        alu_op   = OPW'(map_op);
        alu_a    = a_q[DW-1:0];
        alu_b    = b_q[DW-1:0];
        state_nx = MSW;
      end
      MSW: begin
        alu_op    = OPW'(map_op);
        alu_a     = a_q[2*DW-1:DW];
        alu_b     = b_q[2*DW-1:DW];
        alu_sc_in = cy_q;
        state_nx  = DONE;
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= ADD16;
      a_q        <= '0;
      b_q        <= '0;
      res_lo_q   <= '0;
      cy_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          op_q       <= bus.req_op;
          a_q        <= bus.req_a;
          // B is zeroed for shifts so both halves see ALU_B=0.
          b_q        <= (bus.req_op == LSL16) ? '0 : bus.req_b;
          rsp_err_q  <= (bus.req_op == WIDE_ILL);
          rsp_data_q <= '0;
        end
        LSW: begin
          res_lo_q <= alu_out;
          cy_q     <= (op_q == XOR16) ? 1'b0 : alu_sc_out;
        end
        MSW:     rsp_data_q <= {alu_out, res_lo_q};
        default: ;
      endcase
    end
  end

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err  = rsp_err_q;

`ifdef WIDE_ALU_CARRY_EN
  logic carry_nx, rsp_carry_q;

  // kADDU drops the top carry, so rebuild it from operand and result MSBs.
  always_comb begin
    carry_nx = 1'b0;
    case (op_q)
      ADD16:   carry_nx = (a_q[2*DW-1] & b_q[2*DW-1]) |
                          ((a_q[2*DW-1] | b_q[2*DW-1]) & ~alu_out[DW-1]);
      LSL16:   carry_nx = a_q[2*DW-1];
      default: carry_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 rsp_carry_q <= 1'b0;
    else if (accept)            rsp_carry_q <= 1'b0;
    else if (state == MSW)      rsp_carry_q <= carry_nx;
  end

  assign bus.rsp_carry = rsp_carry_q;
`else
  assign bus.rsp_carry = 1'b0;
`endif
endmodule

// File: tb/tb_wide_alu_seq.sv
// Self-checking bench: wide_alu_seq driving the 8-bit ALU, checked against a 16-bit arithmetic model.
`timescale 1ns/1ps
module tb_wide_alu_seq;
  import wide_alu_seq_pkg::*;
  localparam int DW  = 8;
  localparam int OPW = 4;
`ifdef WIDE_ALU_CARRY_EN
  localparam bit CARRY_EN = 1'b1;
`else
  localparam bit CARRY_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wide_alu_seq_if #(.DW(DW)) bus ();
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_a, alu_b, alu_out;
  logic           alu_sc_in, alu_sc_out;

  wide_alu_seq #(.DW(DW), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_sc_in(alu_sc_in),
    .alu_out(alu_out), .alu_sc_out(alu_sc_out)
  );

  alu #(.DW(DW)) u_alu (
    .op(op_mne'(alu_op)), .inputa(alu_a), .inputb(alu_b), .sc_in(alu_sc_in),
    .out(alu_out), .sc_out(alu_sc_out)
  );

  int checks = 0;
  int failures = 0;
  int lat;
  logic [3:0]  lsw_op, msw_op;
  logic [7:0]  lsw_b, msw_b;
  logic        lsw_sc, msw_sc;
  logic [15:0] exp_d;
  logic        exp_e, exp_c;

  function automatic void model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] d, output logic e, output logic c);
    logic [16:0] s;
    d = '0; e = 1'b0; c = 1'b0;
    case (op)
      2'b00: begin s = {1'b0, a} + {1'b0, b}; d = s[15:0]; c = s[16]; end
      2'b01: begin d = {a[14:0], 1'b0}; c = a[15]; end
      2'b10: d = a ^ b;
      default: e = 1'b1;
    endcase
    if (!CARRY_EN) c = 1'b0;
  endfunction

  // Drives one request and stops at the first negedge with RSP_VALID (or a timeout).
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = wide_op_t'(op); bus.req_a = a; bus.req_b = b;
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    lsw_op = alu_op; lsw_b = alu_b; lsw_sc = alu_sc_in;
    while (!bus.rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin msw_op = alu_op; msw_b = alu_b; msw_sc = alu_sc_in; end
    end
  endtask

  task automatic finish_rsp(input logic keep);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = keep;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", bus.req_ready); end
    checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_carry, bus.rsp_data} !== 19'h0) begin
      failures++; $display("FAIL rst_rsp got=%b%b%b/%h exp=000/0000", bus.rsp_valid, bus.rsp_err, bus.rsp_carry, bus.rsp_data); end
    checks++; if ({alu_op, alu_a, alu_b, alu_sc_in} !== {4'(kADDL), 17'h0}) begin
      failures++; $display("FAIL rst_alu got=%h/%h/%h/%b exp=%h/00/00/0", alu_op, alu_a, alu_b, alu_sc_in, 4'(kADDL)); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      failures++; $display("FAIL idle_after_rst got=%b%b exp=10", bus.req_ready, bus.rsp_valid); end
  endtask

  task automatic test_add;
    issue(2'b00, 16'h00FF, 16'h0001);
    model(2'b00, 16'h00FF, 16'h0001, exp_d, exp_e, exp_c);
    checks++; if (lat !== 3) begin failures++; $display("FAIL add_latency got=%0d exp=3", lat); end
    checks++; if (lsw_op !== 4'(kADDL)) begin failures++; $display("FAIL add_lsw_op got=%h exp=%h", lsw_op, 4'(kADDL)); end
    checks++; if (msw_op !== 4'(kADDU) || msw_sc !== 1'b1) begin failures++; $display("FAIL add_msw got=%h/%b exp=%h/1", msw_op, msw_sc, 4'(kADDU)); end
    checks++; if (bus.rsp_data !== 16'h0100 || bus.rsp_data !== exp_d) begin failures++; $display("FAIL add_data got=%h exp=0100", bus.rsp_data); end
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL done_req_ready got=%b exp=0", bus.req_ready); end
    finish_rsp(1'b0);
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin failures++; $display("FAIL add_release got=%b%b exp=01", bus.rsp_valid, bus.req_ready); end
    issue(2'b00, 16'hFFFF, 16'h0001);
    model(2'b00, 16'hFFFF, 16'h0001, exp_d, exp_e, exp_c);
    checks++; if (bus.rsp_data !== 16'h0000) begin failures++; $display("FAIL add_wrap_data got=%h exp=0000", bus.rsp_data); end
    checks++; if (bus.rsp_carry !== exp_c || bus.rsp_err !== 1'b0) begin failures++; $display("FAIL add_wrap_carry got=%b/%b exp=%b/0", bus.rsp_carry, bus.rsp_err, exp_c); end
    finish_rsp(1'b0);
  endtask

  task automatic test_lsl;
    issue(2'b01, 16'h8180, 16'($urandom_range(1, 65535)));
    model(2'b01, 16'h8180, 16'h0, exp_d, exp_e, exp_c);
    checks++; if (lsw_op !== 4'(kLSAL) || lsw_b !== 8'h00) begin failures++; $display("FAIL lsl_lsw got=%h/%h exp=%h/00", lsw_op, lsw_b, 4'(kLSAL)); end
    checks++; if (msw_op !== 4'(kLSAU) || msw_sc !== 1'b1 || msw_b !== 8'h00) begin
      failures++; $display("FAIL lsl_msw got=%h/%b/%h exp=%h/1/00", msw_op, msw_sc, msw_b, 4'(kLSAU)); end
    checks++; if (bus.rsp_data !== 16'h0300) begin failures++; $display("FAIL lsl_data got=%h exp=0300", bus.rsp_data); end
    checks++; if (bus.rsp_carry !== exp_c) begin failures++; $display("FAIL lsl_carry got=%b exp=%b", bus.rsp_carry, exp_c); end
    finish_rsp(1'b0);
  endtask

  task automatic test_xor;
    issue(2'b10, 16'hA5A5, 16'h0FF0);
    checks++; if (lsw_sc !== 1'b0 || msw_sc !== 1'b0) begin failures++; $display("FAIL xor_sc_in got=%b%b exp=00", lsw_sc, msw_sc); end
    checks++; if (lsw_op !== 4'(kXOR) || msw_op !== 4'(kXOR)) begin failures++; $display("FAIL xor_op got=%h/%h exp=%h", lsw_op, msw_op, 4'(kXOR)); end
    checks++; if (bus.rsp_data !== 16'hAA55 || bus.rsp_carry !== 1'b0) begin failures++; $display("FAIL xor_data got=%h/%b exp=AA55/0", bus.rsp_data, bus.rsp_carry); end
    finish_rsp(1'b0);
  endtask

  task automatic test_illegal;
    issue(2'b11, 16'($urandom), 16'($urandom));
    checks++; if (lat !== 1) begin failures++; $display("FAIL ill_latency got=%0d exp=1", lat); end
    checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_data !== 16'h0 || bus.rsp_carry !== 1'b0) begin
      failures++; $display("FAIL ill_rsp got=%b/%h/%b exp=1/0000/0", bus.rsp_err, bus.rsp_data, bus.rsp_carry); end
    checks++; if (lsw_op !== 4'(kADDL)) begin failures++; $display("FAIL ill_alu_op got=%h exp=%h", lsw_op, 4'(kADDL)); end
    finish_rsp(1'b0);
  endtask

  task automatic test_random;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        keep;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3)); a = 16'($urandom); b = 16'($urandom); keep = 1'($urandom_range(0, 1));
      bus.rsp_ready = keep;
      issue(op, a, b);
      model(op, a, b, exp_d, exp_e, exp_c);
      checks++; if (lat !== ((op == 2'b11) ? 1 : 3)) begin failures++; $display("FAIL rnd_latency n=%0d op=%0d got=%0d", n, op, lat); end
      checks++; if ({bus.rsp_data, bus.rsp_err, bus.rsp_carry} !== {exp_d, exp_e, exp_c}) begin
        failures++; $display("FAIL rnd_rsp n=%0d op=%0d a=%h b=%h got=%h/%b/%b exp=%h/%b/%b", n, op, a, b,
                             bus.rsp_data, bus.rsp_err, bus.rsp_carry, exp_d, exp_e, exp_c); end
      finish_rsp(keep);
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [15:0] a, b, a2, b2, d2;
    logic        e2, c2;
    int          stable_bad, wait_n;
    a = 16'($urandom); b = 16'($urandom); a2 = 16'($urandom); b2 = 16'($urandom);
    model(2'b00, a, b, exp_d, exp_e, exp_c);
    model(2'b10, a2, b2, d2, e2, c2);
    issue(2'b00, a, b);
    bus.req_valid = 1'b1; bus.req_op = XOR16; bus.req_a = a2; bus.req_b = b2;
    stable_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d || bus.req_ready !== 1'b0) stable_bad++;
    end
    checks++; if (stable_bad != 0) begin failures++; $display("FAIL bp_hold bad_cycles=%0d exp=0 data=%h exp_data=%h", stable_bad, bus.rsp_data, exp_d); end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin failures++; $display("FAIL bp_no_same_cycle got=%b%b exp=01", bus.rsp_valid, bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL bp_second_accept got=%b exp=0", bus.req_ready); end
    wait_n = 0;
    while (!bus.rsp_valid && wait_n < 10) begin @(negedge clk); wait_n++; end
    checks++; if (wait_n !== 2) begin failures++; $display("FAIL bp_second_latency got=%0d exp=2", wait_n); end
    checks++; if ({bus.rsp_data, bus.rsp_err, bus.rsp_carry} !== {d2, e2, c2}) begin failures++; $display("FAIL bp_second_data got=%h exp=%h", bus.rsp_data, d2); end
    finish_rsp(1'b0);
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = ADD16; bus.req_a = 16'hC3A5; bus.req_b = 16'h5A3C;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 16'h0 || bus.rsp_err !== 1'b0 || bus.rsp_carry !== 1'b0) begin
      failures++; $display("FAIL mid_rst_rsp got=%b%b/%h/%b%b exp=10/0000/00", bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_carry); end
    checks++; if ({alu_op, alu_a, alu_b, alu_sc_in} !== {4'(kADDL), 17'h0}) begin
      failures++; $display("FAIL mid_rst_alu got=%h/%h/%h/%b exp=%h/00/00/0", alu_op, alu_a, alu_b, alu_sc_in, 4'(kADDL)); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin @(negedge clk); if (bus.rsp_valid !== 1'b0) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL mid_rst_no_rsp got=%0d exp=0", seen); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = ADD16; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
    test_reset;
    test_add;
    test_lsl;
    test_xor;
    test_illegal;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
